// File: rtl/ucsbece154a_rf_wbq.sv
// Writeback queue feeding the register-file write port.
// Requests enter through a valid/ready handshake, are kept in order in a
// circular buffer, and the head is retired onto a3/wd3/we3 every cycle
// while the queue is non-empty. Read-side hazard lookup reports whether a
// pending entry targets each RF read address and returns the youngest
// matching data for bypass.
//
// Ports:
//   clk, reset              clock, async active-high reset
//   req_valid_i/req_ready_o request handshake
//   req_addr_i, req_data_i  request register and data (addr 0 is dropped)
//   a3_o, wd3_o, we3_o      RF write port (head entry)
//   chk1_i, chk2_i          RF read addresses to check for pending writes
//   hit1_o, hit2_o          pending-write hit flags
//   byp1_o, byp2_o          youngest pending data for each read port
//   count_o, full_o, empty_o occupancy status
module ucsbece154a_rf_wbq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [AW-1:0]              req_addr_i,
  input  logic [DW-1:0]              req_data_i,
  output logic [AW-1:0]              a3_o,
  output logic [DW-1:0]              wd3_o,
  output logic                       we3_o,
  input  logic [AW-1:0]              chk1_i,
  input  logic [AW-1:0]              chk2_i,
  output logic                       hit1_o,
  output logic                       hit2_o,
  output logic [DW-1:0]              byp1_o,
  output logic [DW-1:0]              byp2_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  logic push;
  logic pop;

  assign full_o      = (cnt == CW'(DEPTH));
  assign empty_o     = (cnt == '0);
  assign count_o     = cnt;
  assign req_ready_o = !full_o;

  // Writes to x0 complete the handshake but never occupy a slot.
  assign push = req_valid_i && req_ready_o && (req_addr_i != '0);
  // The RF always takes the head write, so a non-empty queue pops every edge.
  assign pop  = !empty_o;

  assign we3_o = !empty_o;
  assign a3_o  = empty_o ? '0 : addr_q[rd_ptr];
  assign wd3_o = empty_o ? '0 : data_q[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage needs no reset: slots are only visible below count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= req_addr_i;
      data_q[wr_ptr] <= req_data_i;
    end
  end

  // Scan from head (oldest) toward the write pointer; later matches
  // overwrite earlier ones so the youngest pending entry wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx    = '0;
    hit1_o = 1'b0;
    hit2_o = 1'b0;
    byp1_o = '0;
    byp2_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < cnt) begin
        if ((chk1_i != '0) && (addr_q[idx] == chk1_i)) begin
          hit1_o = 1'b1;
          byp1_o = data_q[idx];
        end
        if ((chk2_i != '0) && (addr_q[idx] == chk2_i)) begin
          hit2_o = 1'b1;
          byp2_o = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154a_rf_wbq.sv
// Bench for the RF writeback queue: directed vector table, hand-written
// reset/wrap sequences, and randomized traffic against a queue-based model.
module tb_ucsbece154a_rf_wbq;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_data_i = '0;
  logic [AW-1:0] a3_o;
  logic [DW-1:0] wd3_o;
  logic          we3_o;
  logic [AW-1:0] chk1_i = '0;
  logic [AW-1:0] chk2_i = '0;
  logic          hit1_o, hit2_o;
  logic [DW-1:0] byp1_o, byp2_o;
  logic [CW-1:0] count_o;
  logic          full_o, empty_o;

  ucsbece154a_rf_wbq #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .a3_o(a3_o), .wd3_o(wd3_o), .we3_o(we3_o),
    .chk1_i(chk1_i), .chk2_i(chk2_i),
    .hit1_o(hit1_o), .hit2_o(hit2_o),
    .byp1_o(byp1_o), .byp2_o(byp2_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t mq[$];     // model of pending entries, oldest first
  ent_t exp_w[$];  // RF writes that must happen, in order
  ent_t obs_w[$];  // RF writes seen on the DUT port

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [AW-1:0] c;
    logic          e_we;
    logic [AW-1:0] e_a3;
    logic [DW-1:0] e_wd;
    logic          e_hit;
    logic [DW-1:0] e_byp;
    int            e_cnt;
  } vec_t;

  vec_t vt[9];

  task automatic cmp(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic void ref_hit(input logic [AW-1:0] c, output logic h, output logic [DW-1:0] b);
    h = 1'b0;
    b = '0;
    if (c != '0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].addr == c) begin
          h = 1'b1;
          b = mq[i].data;
          break;
        end
      end
    end
  endfunction

  task automatic check_model();
    logic          h;
    logic [DW-1:0] b;
    int            n;
    n = mq.size();
    cmp("we3",   32'(we3_o),       32'(n > 0));
    cmp("a3",    32'(a3_o),        (n > 0) ? 32'(mq[0].addr) : 32'd0);
    cmp("wd3",   wd3_o,            (n > 0) ? mq[0].data : 32'd0);
    cmp("count", 32'(count_o),     32'(n));
    cmp("empty", 32'(empty_o),     32'(n == 0));
    cmp("full",  32'(full_o),      32'(n == DEPTH));
    cmp("ready", 32'(req_ready_o), 32'(n < DEPTH));
    ref_hit(chk1_i, h, b);
    cmp("hit1", 32'(hit1_o), 32'(h));
    cmp("byp1", byp1_o, b);
    ref_hit(chk2_i, h, b);
    cmp("hit2", 32'(hit2_o), 32'(h));
    cmp("byp2", byp2_o, b);
    if (we3_o === 1'b1) obs_w.push_back('{a3_o, wd3_o});
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [AW-1:0] c1, input logic [AW-1:0] c2);
    @(negedge clk);
    req_valid_i = v;
    req_addr_i  = a;
    req_data_i  = d;
    chk1_i      = c1;
    chk2_i      = c2;
    #1;
    check_model();
  endtask

  task automatic tick();
    logic acc;
    ent_t e;
    @(posedge clk);
    acc = req_valid_i && (mq.size() < DEPTH);
    if (mq.size() > 0) mq.delete(0);
    if (acc && (req_addr_i != '0)) begin
      e = '{req_addr_i, req_data_i};
      mq.push_back(e);
      exp_w.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, "_we3"},   32'(we3_o),       32'd0);
    cmp({tag, "_a3"},    32'(a3_o),        32'd0);
    cmp({tag, "_wd3"},   wd3_o,            32'd0);
    cmp({tag, "_count"}, 32'(count_o),     32'd0);
    cmp({tag, "_empty"}, 32'(empty_o),     32'd1);
    cmp({tag, "_full"},  32'(full_o),      32'd0);
    cmp({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    cmp({tag, "_hit1"},  32'(hit1_o),      32'd0);
    cmp({tag, "_byp1"},  byp1_o,           32'd0);
  endtask

  initial begin
    // expected values are the outputs before the edge that applies the row
    vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        0};
    vt[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1};
    vt[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        0};
    vt[3] = '{1'b1, 5'd7, 32'h7,        5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        0};
    vt[4] = '{1'b1, 5'd9, 32'hA,        5'd7, 1'b1, 5'd7, 32'h7,        1'b1, 32'h7,        1};
    vt[5] = '{1'b1, 5'd9, 32'hB,        5'd9, 1'b1, 5'd9, 32'hA,        1'b1, 32'hA,        1};
    vt[6] = '{1'b1, 5'd3, 32'hC,        5'd9, 1'b1, 5'd9, 32'hB,        1'b1, 32'hB,        1};
    vt[7] = '{1'b0, 5'd0, 32'h0,        5'd9, 1'b1, 5'd3, 32'hC,        1'b0, 32'h0,        1};
    vt[8] = '{1'b0, 5'd0, 32'h0,        5'd3, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        0};

    #2;
    check_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(vt[i].v, vt[i].a, vt[i].d, vt[i].c, vt[i].c);
      cmp($sformatf("vec%0d_we3", i),   32'(we3_o),   32'(vt[i].e_we));
      cmp($sformatf("vec%0d_a3", i),    32'(a3_o),    32'(vt[i].e_a3));
      cmp($sformatf("vec%0d_wd3", i),   wd3_o,        vt[i].e_wd);
      cmp($sformatf("vec%0d_hit2", i),  32'(hit2_o),  32'(vt[i].e_hit));
      cmp($sformatf("vec%0d_byp2", i),  byp2_o,       vt[i].e_byp);
      cmp($sformatf("vec%0d_count", i), 32'(count_o), 32'(vt[i].e_cnt));
      tick();
    end

    // wrap-around: ten back-to-back pushes across pointer wrap
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, AW'(i), 32'(i * 32'h11), AW'(i - 1), AW'(i));
      if (i > 1) cmp($sformatf("wrap%0d_count", i), 32'(count_o), 32'd1);
      tick();
    end

    // reset mid-drain: the pending head must never reach the RF
    drive(1'b1, 5'd5, 32'h55, 5'd0, 5'd0); tick();
    drive(1'b1, 5'd6, 32'h66, 5'd0, 5'd0); tick();
    drive(1'b1, 5'd7, 32'h77, 5'd7, 5'd0); tick();
    #2;
    req_valid_i = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("rstmid");
    repeat (mq.size()) void'(exp_w.pop_back());
    mq.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd6);
      tick();
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      tick();
    end

    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      tick();
    end

    cmp("rf_nwrites", 32'(obs_w.size()), 32'(exp_w.size()));
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
      if (obs_w[i] != exp_w[i]) begin
        cmp($sformatf("rf_w%0d_addr", i), 32'(obs_w[i].addr), 32'(exp_w[i].addr));
        cmp($sformatf("rf_w%0d_data", i), obs_w[i].data, exp_w[i].data);
      end else begin
        total++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
